modprod_serial: RTL and testbench



---
 rtl/rsa_pkg.sv | 22 ++
 rtl/modprod_serial_if.sv | 15 +
 rtl/mod_addsub.sv | 19 +
 rtl/modprod_serial.sv | 138 +++++++++++++
 tb/tb_modprod_serial.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA datapath: operand width, FSM states, word types.
package rsa_pkg;

  localparam int W = 256;

  // Bit counter walks from W-1 down to 0.
  localparam int IDX_W = $clog2(W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    MULT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef logic [W-1:0]     word_t;
  typedef logic [W:0]       wide_t;
  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t LAST_IDX = idx_t'(W - 1);

endpackage

// File: rtl/modprod_serial_if.sv
// Request/result bundle of the serial modular multiplier.
interface modprod_serial_if;
  import rsa_pkg::*;

  logic  start;
  word_t N;
  word_t a;
  word_t b;
  word_t m;
  logic  finish;

  modport master (output start, N, a, b, input m, finish);
  modport slave  (input start, N, a, b, output m, finish);

endinterface

// File: rtl/mod_addsub.sv
// Single conditional subtract: y = (x >= n) ? x - n : x.
// The caller guarantees x < 2n, so the result always fits in one word.
module mod_addsub
  import rsa_pkg::*;
(
  input  wide_t x,
  input  word_t n,
  output word_t y
);

  logic ge;

  // Low-word subtraction is exact because the true difference is below 2^W.
  always_comb begin
    ge = (x >= {1'b0, n});
    y  = ge ? (x[W-1:0] - n) : x[W-1:0];
  end

endmodule

// File: rtl/modprod_serial.sv
// Bit-serial 256-bit modular multiplier, m = (a*b) mod N.
// Pass 1 reduces b modulo N (MSB-first shift-in). Pass 2 runs Horner over a
// with one doubling reduction and one optional add reduction per bit.
module modprod_serial
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,   // active-high despite the legacy name
  modprod_serial_if.slave  bus
);

  state_e state_q, state_d;
  idx_t   i_q, i_d;
  word_t  n_q, n_d;
  word_t  a_q, a_d;
  word_t  b_q, b_d;
  word_t  bred_q, bred_d;
  word_t  r_q, r_d;
  word_t  m_q, m_d;
  logic   nzero_q, nzero_d;
  logic   finish_q, finish_d;

  wide_t  dbl_x;
  word_t  dbl_y;
  wide_t  add_x;
  word_t  add_y;
  word_t  r_next;

  // Shift step: 2r + b[i] while reducing b, plain 2r while multiplying.
  always_comb begin
    dbl_x = (state_q == REDUCE) ? {r_q, b_q[i_q]} : {r_q, 1'b0};
    add_x = {1'b0, dbl_y} + {1'b0, bred_q};
  end

  mod_addsub u_dbl (
    .x (dbl_x),
    .n (n_q),
    .y (dbl_y)
  );

  mod_addsub u_add (
    .x (add_x),
    .n (n_q),
    .y (add_y)
  );

  // Next-state, counter and datapath register selection.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    n_d      = n_q;
    a_d      = a_q;
    b_d      = b_q;
    bred_d   = bred_q;
    r_d      = r_q;
    m_d      = m_q;
    nzero_d  = nzero_q;
    finish_d = 1'b0;
    r_next   = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d     = bus.N;
          a_d     = bus.a;
          b_d     = bus.b;
          nzero_d = (bus.N == '0);
          r_d     = '0;
          i_d     = LAST_IDX;
          state_d = REDUCE;
        end
      end

      REDUCE: begin
        // A zero modulus pins the accumulator at zero so m comes out as 0.
        r_next = nzero_q ? '0 : dbl_y;
        r_d    = r_next;
        i_d    = i_q - 1'b1;
        if (i_q == '0) begin
          bred_d  = r_next;
          r_d     = '0;
          i_d     = LAST_IDX;
          state_d = MULT;
        end
      end

      MULT: begin
        r_next = nzero_q ? '0 : (a_q[i_q] ? add_y : dbl_y);
        r_d    = r_next;
        i_d    = i_q - 1'b1;
        if (i_q == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        m_d      = r_q;
        finish_d = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts a run.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      n_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      bred_q   <= '0;
      r_q      <= '0;
      m_q      <= '0;
      nzero_q  <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      n_q      <= n_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bred_q   <= bred_d;
      r_q      <= r_d;
      m_q      <= m_d;
      nzero_q  <= nzero_d;
      finish_q <= finish_d;
    end
  end

  assign bus.m      = m_q;
  assign bus.finish = finish_q;

endmodule

// File: tb/tb_modprod_serial.sv
// Scoreboard bench for modprod_serial: expected products are queued when a
// request is driven and popped by a monitor whenever finish pulses.
module tb_modprod_serial;
  import rsa_pkg::*;

  localparam int LATENCY = 513;
  localparam int BOUND   = 700;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  modprod_serial_if bus ();

  modprod_serial dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_chk  = 0;
  int    n_fail = 0;
  int    fin_cnt = 0;
  int    ops_expected = 0;
  word_t exp_q[$];

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: full 512-bit product, then modulo.
  function automatic word_t ref_mod(input word_t x, input word_t y, input word_t n);
    logic [2*W-1:0] p;
    if (n == '0) return '0;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    p = p % {{W{1'b0}}, n};
    return p[W-1:0];
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Monitor: every finish pulse must match the head of the scoreboard.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.finish === 1'b1) begin
        fin_cnt++;
        check("finish_width", word_t'(prev), '0);
        if (exp_q.size() == 0) check("spurious_finish", word_t'(bus.finish), '0);
        else check("m", bus.m, exp_q.pop_front());
      end
      prev = bus.finish;
    end
  end

  // Drive one request; start held for `hold` cycles, optional re-pulse of
  // start at cycle `restart_at` after the sampling edge (must be ignored).
  task automatic run_op(input word_t x, input word_t y, input word_t n,
                        input int hold, input int restart_at);
    int lat;
    bit seen;
    @(negedge clk);
    bus.a = x; bus.b = y; bus.N = n; bus.start = 1'b1;
    exp_q.push_back(ref_mod(x, y, n));
    ops_expected++;
    lat = 0; seen = 1'b0;
    for (int c = 0; c < BOUND && !seen; c++) begin
      @(posedge clk);
      #1;
      if (c >= 1 && bus.finish === 1'b1) begin
        seen = 1'b1;
        lat  = c;
      end
      if (c == hold - 1) begin
        bus.start = 1'b0;
        bus.a = 3; bus.b = 11; bus.N = 13;
      end
      if (restart_at > 0 && c == restart_at) begin
        bus.a = rand_word(); bus.b = rand_word(); bus.N = 97;
        bus.start = 1'b1;
      end
      if (restart_at > 0 && c == restart_at + 1) bus.start = 1'b0;
    end
    if (!seen) check("timeout", word_t'(seen), word_t'(1));
    else check("latency", word_t'(lat), word_t'(LATENCY));
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    word_t big_n, ones;
    rst_n = 1'b1;
    bus.start = 1'b0;
    bus.a = '0; bus.b = '0; bus.N = '0;

    // Reset with start pulsed during it: nothing may come out.
    idle(2);
    bus.a = 5; bus.b = 7; bus.N = 11; bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
    idle(1);
    rst_n = 1'b0;
    #1;
    check("reset_m", bus.m, '0);
    check("reset_finish", word_t'(bus.finish), '0);
    idle(600);
    check("idle_m", bus.m, '0);

    // Operands larger than N; inputs change right after start.
    run_op(279, 398, 221, 1, 0);
    idle(2);
    run_op(3, 11, 13, 1, 0);
    idle(1);

    // start re-pulsed mid-run is ignored; wait past where a second run would end.
    run_op(1000, 2000, 997, 1, 280);
    idle(400);

    // start held for three cycles yields exactly one operation.
    run_op(12345, 67890, 1009, 3, 0);
    idle(5);

    // Edge operands.
    run_op(0, 77, 101, 1, 0);
    run_op(123, 456, 1, 1, 0);
    run_op(123, 456, 0, 1, 0);
    ones  = '1;
    big_n = ones - word_t'(188);  // 2^256 - 189, so a = b = N + 188
    run_op(ones, ones, big_n, 1, 0);
    check("big_result", bus.m, word_t'(188 * 188));

    // Random full-width operands.
    for (int k = 0; k < 2; k++) run_op(rand_word(), rand_word(), rand_word(), 1, 0);

    // Reset during MULT aborts without a finish pulse.
    @(negedge clk);
    bus.a = 279; bus.b = 398; bus.N = 221; bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
    idle(400);
    rst_n = 1'b1;
    idle(1);
    rst_n = 1'b0;
    #1;
    check("abort_m", bus.m, '0);
    check("abort_finish", word_t'(bus.finish), '0);
    idle(600);
    check("abort_m_hold", bus.m, '0);

    // Normal operation after the abort.
    run_op(3, 11, 13, 1, 0);
    idle(5);

    check("finish_count", word_t'(fin_cnt), word_t'(ops_expected));
    check("queue_drained", word_t'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
